// File: rtl/vip_fifo_pkg.sv
// Shared FIFO defaults and width helpers used by the pixel FIFO family.
package vip_fifo_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_CHANNELS   = 3;
    localparam int DEF_DEPTH      = 25;

    // Bits needed to hold an occupancy value in 0..depth.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Bits needed to hold a wrap index in 0..depth-1 (at least one bit).
    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/fifo_wrap_ptr.sv
// Wrapping FIFO pointer: index counts 0..DEPTH-1 and a lap bit flips on every wrap,
// so two pointers can tell "same slot, same lap" (empty) from "same slot, one lap apart" (full).
module fifo_wrap_ptr
    import vip_fifo_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH
)(
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        clr,
    input  logic                        inc,
    output logic [idx_width(DEPTH)-1:0] idx,
    output logic                        lap
);

    localparam int IW = idx_width(DEPTH);

    logic [IW-1:0] idx_q, idx_d;
    logic          lap_q, lap_d;

    // Next pointer: flush wins, otherwise step and wrap at the last slot.
    always_comb begin
        idx_d = idx_q;
        lap_d = lap_q;
        if (clr) begin
            idx_d = '0;
            lap_d = 1'b0;
        end else if (inc) begin
            if (idx_q == IW'(DEPTH - 1)) begin
                idx_d = '0;
                lap_d = ~lap_q;
            end else begin
                idx_d = idx_q + IW'(1);
            end
        end
    end

    // Pointer register with asynchronous reset to slot 0, lap 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q <= '0;
            lap_q <= 1'b0;
        end else begin
            idx_q <= idx_d;
            lap_q <= lap_d;
        end
    end

    assign idx = idx_q;
    assign lap = lap_q;

endmodule

// File: rtl/pixel_fifo.sv
// Synchronous multi-channel pixel FIFO with registered read data, occupancy count,
// threshold flags and sticky overflow/underflow error flags.
module pixel_fifo
    import vip_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int CHANNELS   = DEF_CHANNELS,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int AF_LEVEL   = DEPTH - 2,
    parameter int AE_LEVEL   = 2
)(
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           clr,
    input  logic                           wr_req,
    input  logic [DATA_WIDTH*CHANNELS-1:0] data_in,
    input  logic                           rd_req,
    output logic [DATA_WIDTH*CHANNELS-1:0] data_out,
    output logic                           rd_valid,
    output logic                           full,
    output logic                           empty,
    output logic                           almost_full,
    output logic                           almost_empty,
    output logic [cnt_width(DEPTH)-1:0]    count,
    output logic                           overflow,
    output logic                           underflow
);

    localparam int EW = DATA_WIDTH * CHANNELS;
    localparam int IW = idx_width(DEPTH);
    localparam int CW = cnt_width(DEPTH);

    if (DEPTH < 2) begin : gBadDepth
        $error("pixel_fifo: DEPTH must be at least 2");
    end
    if (AE_LEVEL >= AF_LEVEL) begin : gBadLevels
        $error("pixel_fifo: AE_LEVEL must be below AF_LEVEL");
    end
    if (AF_LEVEL > DEPTH) begin : gBadAf
        $error("pixel_fifo: AF_LEVEL must not exceed DEPTH");
    end

    logic [EW-1:0] mem [DEPTH];

    logic [IW-1:0] wrIdx, rdIdx;
    logic          wrLap, rdLap;
    logic          wrAccept, rdAccept;

    logic [CW-1:0] count_q, count_d;
    logic [EW-1:0] data_out_q, data_out_d;
    logic          rd_valid_q, rd_valid_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;

    // Status flags come only from the pointer and count registers.
    assign empty        = (wrIdx == rdIdx) && (wrLap == rdLap);
    assign full         = (wrIdx == rdIdx) && (wrLap != rdLap);
    assign almost_full  = (count_q >= CW'(AF_LEVEL));
    assign almost_empty = (count_q <= CW'(AE_LEVEL));

    assign wrAccept = wr_req && !full  && !clr;
    assign rdAccept = rd_req && !empty && !clr;

    fifo_wrap_ptr #(.DEPTH(DEPTH)) uWrPtr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .inc   (wrAccept),
        .idx   (wrIdx),
        .lap   (wrLap)
    );

    fifo_wrap_ptr #(.DEPTH(DEPTH)) uRdPtr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .inc   (rdAccept),
        .idx   (rdIdx),
        .lap   (rdLap)
    );

    // Storage write: only accepted writes land in the array; contents are never reset.
    always_ff @(posedge clk) begin
        if (wrAccept) begin
            mem[wrIdx] <= data_in;
        end
    end

    // Next count, read data and error flags; flush clears everything but held data.
    always_comb begin
        count_d     = count_q;
        data_out_d  = data_out_q;
        rd_valid_d  = 1'b0;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (clr) begin
            count_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (wrAccept && !rdAccept) begin
                count_d = count_q + CW'(1);
            end else if (rdAccept && !wrAccept) begin
                count_d = count_q - CW'(1);
            end
            if (rdAccept) begin
                data_out_d = mem[rdIdx];
                rd_valid_d = 1'b1;
            end
            if (wr_req && full) begin
                overflow_d = 1'b1;
            end
            if (rd_req && empty) begin
                underflow_d = 1'b1;
            end
        end
    end

    // Output and bookkeeping registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q     <= '0;
            data_out_q  <= '0;
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            data_out_q  <= data_out_d;
            rd_valid_q  <= rd_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign count     = count_q;
    assign data_out  = data_out_q;
    assign rd_valid  = rd_valid_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: doc/pixel_fifo.md
PIXEL_FIFO -- requirements
Module: pixel_fifo

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 32, which is the bits per channel.
REQ-002 The module SHALL have parameter CHANNELS, default 3, which is the channels packed per entry.
REQ-003 The module SHALL have parameter DEPTH, default 25, which is the entry count; any value >= 2 is legal, including non-powers of two.
REQ-004 The module SHALL have parameter AF_LEVEL, default DEPTH-2, which is the almost-full threshold in entries.
REQ-005 The module SHALL have parameter AE_LEVEL, default 2, which is the almost-empty threshold in entries.
REQ-006 The module SHALL have input clk, 1 bit, the single clock; all logic is on its rising edge.
REQ-007 The module SHALL have input rst_n, 1 bit, an asynchronous active-low reset.
REQ-008 The module SHALL have input clr, 1 bit, a synchronous flush.
REQ-009 The module SHALL have input wr_req, 1 bit, a write request.
REQ-010 The module SHALL have input data_in, DATA_WIDTH*CHANNELS bits, the write entry; channel k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-011 The module SHALL have input rd_req, 1 bit, a read request.
REQ-012 The module SHALL have output data_out, DATA_WIDTH*CHANNELS bits, the registered read entry.
REQ-013 The module SHALL have output rd_valid, 1 bit, asserted when data_out carries a newly read entry.
REQ-014 The module SHALL have outputs full, empty, almost_full and almost_empty, 1 bit each, the status flags.
REQ-015 The module SHALL have output count, $clog2(DEPTH+1) bits, the current occupancy.
REQ-016 The module SHALL have outputs overflow and underflow, 1 bit each, sticky error flags.

Function
REQ-017 A write SHALL be accepted iff wr_req=1 and full=0; a read SHALL be accepted iff rd_req=1 and empty=0; decisions use pre-edge flag values.
REQ-018 Each of the read and write pointers SHALL be a wrap index in 0..DEPTH-1 plus a lap bit; the index SHALL wrap from DEPTH-1 to 0 and the lap bit SHALL toggle on wrap.
REQ-019 empty SHALL equal (indices equal AND lap bits equal); full SHALL equal (indices equal AND lap bits differ).
REQ-020 count SHALL increment by 1 on a write-only accept, decrement by 1 on a read-only accept, and hold when both or neither are accepted.
REQ-021 count SHALL always equal the occupancy derived from the pointers.
REQ-022 almost_full SHALL equal (count >= AF_LEVEL); almost_empty SHALL equal (count <= AE_LEVEL); all flags SHALL be registered or derived from registers, never from wr_req or rd_req.
REQ-023 Read latency SHALL be one cycle: an accepted read at edge N updates data_out and sets rd_valid=1 after edge N.
REQ-024 rd_valid SHALL be 0 in any cycle after an edge with no accepted read; data_out SHALL hold its last value when no read is accepted.
REQ-025 With both wr_req and rd_req asserted while empty: the write SHALL be accepted, the read rejected, underflow set, and the new entry not bypassed.
REQ-026 With both wr_req and rd_req asserted while full: the read SHALL be accepted, the write rejected, overflow set, and count becomes DEPTH-1.
REQ-027 With both accepted in a non-boundary state: count is unchanged and both pointers advance.
REQ-028 overflow SHALL set on wr_req while full, and underflow SHALL set on rd_req while empty; both SHALL remain set until clr or reset.
REQ-029 clr=1 SHALL, at the next edge, zero both pointers, count, rd_valid, overflow and underflow; it SHALL take priority over simultaneous wr_req and rd_req, which are ignored; RAM contents are don't-care.
REQ-030 Storage SHALL be a DEPTH x (DATA_WIDTH*CHANNELS) array written synchronously; it SHALL have no combinational or latch-inferred write path.

Reset
REQ-031 When rst_n=0, asynchronously: pointers=0, count=0, empty=1, full=0, almost_empty=1, almost_full=(AF_LEVEL==0), rd_valid=0, data_out=0, overflow=0, underflow=0.
REQ-032 Reset mid-operation SHALL discard all stored entries; the first accepted write after release SHALL be the first read.
REQ-033 Reset SHALL be released synchronously by the integrator; the block SHALL take no reset synchronizer.

Structure
REQ-034 A shared package vip_fifo_pkg SHALL hold the default DATA_WIDTH, CHANNELS and DEPTH values and a count/pointer width function; it SHALL not contain module-specific logic.
REQ-035 One sub-module, fifo_wrap_ptr (parameter DEPTH; inputs clk, rst_n, clr, inc; outputs idx, lap), SHALL be instantiated twice, once for read and once for write.
REQ-036 Elaboration SHALL fail if DEPTH<2 or AE_LEVEL>=AF_LEVEL or AF_LEVEL>DEPTH.

Verification
REQ-037 Fill/drain, DEPTH=25: write 25 entries 0x1..0x19 per channel -> full=1 at count=25; read 25 -> identical order, rd_valid one cycle after each rd_req, empty=1.
REQ-038 Wrap-around, DEPTH=25: loop 60 cycles of concurrent write and read after pre-filling 3 -> count stays 3, data in order across two lap toggles.
REQ-039 Overflow/underflow: write while full -> overflow=1, count stays 25; read while empty -> underflow=1, rd_valid=0; clr -> both flags 0, count=0.
REQ-040 Simultaneous at boundaries: wr_req+rd_req while empty -> count=1, underflow=1; while full -> count=24, overflow=1, read data = oldest entry.
REQ-041 Thresholds, AF_LEVEL=23, AE_LEVEL=2: almost_empty deasserts when count goes 2->3; almost_full asserts when count goes 22->23.
REQ-042 Async reset at count=10 mid-read -> all outputs at REQ-031 values without a clock edge; a subsequent write of 0xAA then read returns 0xAA.
